pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Holds the MIPS32 program counter, fetches one instruction per step over a req/ack
//  instruction-memory handshake and selects the next PC. Consumes the <<2 outputs of the
//  shift_circuit stages (branch offset, jump index) and feeds decode with instr/pc_plus4.
//  Priority redirect: exception > jr > j/jal > taken branch > sequential.
// PARAMETERS
//  DATA_WIDTH  32            datapath/PC width
//  RESET_PC    32'h0000_0000 PC loaded on reset
//  EXC_VECTOR  32'h0000_0180 PC loaded on exception or misaligned target
// PORTS
//  clk              in   1   single clock, rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  stall            in   1   hold EXEC step; redirect inputs ignored while high
//  exc              in   1   exception for instruction in EXEC
//  jump_reg         in   1   jr/jalr taken
//  jr_target        in   32  rs value for jr
//  jump             in   1   j/jal taken
//  jump_index_sh    in   28  instr[25:0]<<2
//  branch_taken     in   1   conditional branch resolved taken
//  branch_offset_sh in   32  sign-extended imm<<2
//  imem_req         out  1   fetch request, level, held until ack
//  imem_addr        out  32  fetch address (= pc_out)
//  imem_ack         in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata       in   32  fetched word
//  instr            out  32  registered instruction
//  instr_valid      out  1   high in every EXEC cycle
//  pc_out           out  32  current PC
//  pc_plus4         out  32  pc_out+4 (link value, branch base)
//  misalign_err     out  1   1-cycle pulse: selected target[1:0]!=0
// BEHAVIOUR
//  Reset (async on rst_n=0): pc=RESET_PC, state=FETCH, imem_req=0, instr=0,
//   instr_valid=0, misalign_err=0. First imem_req=1 on first clk edge after release.
//  FSM: FETCH -> EXEC on imem_ack (instr<=imem_rdata); EXEC -> FETCH when stall=0;
//   EXEC -> EXEC while stall=1 (pc, instr held).
//  FETCH: imem_req=1, imem_addr=pc; ack may arrive in the first req cycle (0-wait) or later.
//  EXEC, stall=0: sample redirects, pc<=next_pc at that edge:
//   exc -> EXEC_VECTOR; jump_reg -> jr_target; jump -> {pc_plus4[31:28],jump_index_sh};
//   branch_taken -> pc_plus4+branch_offset_sh; else pc_plus4. Multiple asserted: priority.
//  Misaligned: if selected target[1:0]!=0, pc<=EXEC_VECTOR, misalign_err=1 for that cycle.
//  Arithmetic mod 2^32: pc 32'hFFFF_FFFC -> pc_plus4=0; branch base wraps likewise.
//  Throughput: 0-wait memory gives one instruction per 2 cycles.
//  imem_ack outside FETCH is ignored. Reset mid-fetch: req drops immediately, pending ack lost.
//  pc_plus4 combinational from pc; all other outputs registered or state-decoded.
// STRUCTURE
//  Shared package mips_pkg: RESET_PC/EXC_VECTOR defaults, fetch_state_t {FETCH,EXEC},
//   next-PC select enum {NPC_SEQ,NPC_BR,NPC_J,NPC_JR,NPC_EXC}.
//  One sub-module: next_pc_mux (combinational priority select + alignment check);
//   top holds FSM, pc and instr registers.
// TESTING
//  Reset then 0-wait ack: imem_addr=0, 0x4, 0x8 on successive FETCH; instr_valid every 2nd cycle.
//  Ack delayed 3 cycles at pc=0x10: req stays 1, addr stays 0x10, instr_valid only after ack.
//  pc=0x100, branch_taken, offset_sh=0xFFFF_FFF0 -> next addr 0xF4; jump=1 too -> j wins.
//  jump_reg, jr_target=0x0000_2002 -> misalign_err pulse, next addr 0x180.
//  stall=1 for 4 EXEC cycles with branch_taken toggling -> pc/instr frozen, redirect taken
//   only from values on the stall=0 cycle; rst_n=0 mid-FETCH -> req 0, pc=0 asynchronously.
//  pc=0xFFFF_FFFC sequential -> pc_plus4=0, next fetch addr 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 front-end types: fetch FSM states, next-PC select codes, reset/exception defaults.
package mips_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } fetch_state_t;

   typedef enum logic [2:0] {
      NPC_SEQ = 3'd0,
      NPC_BR  = 3'd1,
      NPC_J   = 3'd2,
      NPC_JR  = 3'd3,
      NPC_EXC = 3'd4
   } npc_sel_t;

   // Word fetches require the two low address bits clear.
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Priority next-PC selection (exc > jr > j > branch > seq) with word-alignment fallback to the exception vector.
module next_pc_mux
   import mips_pkg::*;
#(
   parameter int unsigned                  DATA_WIDTH = mips_pkg::DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0]        EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic [DATA_WIDTH-1:0] pc_plus4,
   input  logic                  exc,
   input  logic                  jump_reg,
   input  logic [DATA_WIDTH-1:0] jr_target,
   input  logic                  jump,
   input  logic [DATA_WIDTH-5:0] jump_index_sh,
   input  logic                  branch_taken,
   input  logic [DATA_WIDTH-1:0] branch_offset_sh,
   output logic [DATA_WIDTH-1:0] next_pc_c,
   output logic                  misalign_c
);

   npc_sel_t              sel;
   logic [DATA_WIDTH-1:0] target;

   // Priority encode the redirect requests.
   always_comb begin
      sel = NPC_SEQ;
      if (exc)               sel = NPC_EXC;
      else if (jump_reg)     sel = NPC_JR;
      else if (jump)         sel = NPC_J;
      else if (branch_taken) sel = NPC_BR;
   end

   // Target generation; all sums wrap modulo 2^DATA_WIDTH.
   always_comb begin
      target = pc_plus4;
      case (sel)
         NPC_EXC: target = EXC_VECTOR;
         NPC_JR:  target = jr_target;
         NPC_J:   target = {pc_plus4[DATA_WIDTH-1:DATA_WIDTH-4], jump_index_sh};
         NPC_BR:  target = pc_plus4 + branch_offset_sh;
         default: target = pc_plus4;
      endcase
   end

   always_comb begin
      misalign_c = is_misaligned(target[1:0]);
      next_pc_c  = misalign_c ? EXC_VECTOR : target;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS32 program counter and instruction fetch: req/ack fetch, EXEC step with stall, next-PC redirect.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = mips_pkg::DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  exc,
   input  logic                  jump_reg,
   input  logic [DATA_WIDTH-1:0] jr_target,
   input  logic                  jump,
   input  logic [DATA_WIDTH-5:0] jump_index_sh,
   input  logic                  branch_taken,
   input  logic [DATA_WIDTH-1:0] branch_offset_sh,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  misalign_err
);

   fetch_state_t          state;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] next_pc;
   logic                  misalign;

   assign pc_plus4  = pc + DATA_WIDTH'(4);
   assign pc_out    = pc;
   assign imem_addr = pc;

   next_pc_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc_mux (
      .pc_plus4         (pc_plus4),
      .exc              (exc),
      .jump_reg         (jump_reg),
      .jr_target        (jr_target),
      .jump             (jump),
      .jump_index_sh    (jump_index_sh),
      .branch_taken     (branch_taken),
      .branch_offset_sh (branch_offset_sh),
      .next_pc_c        (next_pc),
      .misalign_c       (misalign)
   );

   // Fetch/exec sequencer; req is raised one edge after reset so a stale ack is never taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         instr        <= '0;
         instr_valid  <= 1'b0;
         imem_req     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         case (state)
            FETCH: begin
               if (imem_req && imem_ack) begin
                  state       <= EXEC;
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            EXEC: begin
               if (!stall) begin
                  state        <= FETCH;
                  pc           <= next_pc;
                  misalign_err <= misalign;
                  instr_valid  <= 1'b0;
                  imem_req     <= 1'b1;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch handshake, redirect priority, misalignment, stall, reset, wrap.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        exc;
   logic        jump_reg;
   logic [31:0] jr_target;
   logic        jump;
   logic [27:0] jump_index_sh;
   logic        branch_taken;
   logic [31:0] branch_offset_sh;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        misalign_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_instr;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .exc              (exc),
      .jump_reg         (jump_reg),
      .jr_target        (jr_target),
      .jump             (jump),
      .jump_index_sh    (jump_index_sh),
      .branch_taken     (branch_taken),
      .branch_offset_sh (branch_offset_sh),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_rdata       (imem_rdata),
      .instr            (instr),
      .instr_valid      (instr_valid),
      .pc_out           (pc_out),
      .pc_plus4         (pc_plus4),
      .misalign_err     (misalign_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_redirects();
      exc              = 1'b0;
      jump_reg         = 1'b0;
      jr_target        = '0;
      jump             = 1'b0;
      jump_index_sh    = '0;
      branch_taken     = 1'b0;
      branch_offset_sh = '0;
   endtask

   // Serve one fetch at exp_addr after wait_n idle cycles; leaves the DUT in EXEC at a negedge.
   task automatic fetch(input int wait_n, input logic [31:0] exp_addr);
      int n = 0;
      while (!imem_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("req_up", 32'(imem_req), 32'd1);
      check("fetch_addr", imem_addr, exp_addr);
      for (int i = 0; i < wait_n; i++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         check("req_held", 32'(imem_req), 32'd1);
         check("addr_held", imem_addr, exp_addr);
         check("valid_wait", 32'(instr_valid), 32'd0);
      end
      last_instr = exp_addr ^ 32'hDEAD_0000;
      imem_ack   = 1'b1;
      imem_rdata = last_instr;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'h0BAD_0BAD;
      check("exec_valid", 32'(instr_valid), 32'd1);
      check("exec_instr", instr, last_instr);
      check("exec_req", 32'(imem_req), 32'd0);
      check("exec_pc", pc_out, exp_addr);
      check("exec_mis", 32'(misalign_err), 32'd0);
   endtask

   // Leave EXEC with the currently driven redirects; check the following FETCH cycle.
   task automatic exec_step(input logic [31:0] exp_next, input logic exp_mis);
      stall = 1'b0;
      @(negedge clk);
      clear_redirects();
      check("next_addr", imem_addr, exp_next);
      check("next_req", 32'(imem_req), 32'd1);
      check("next_valid", 32'(instr_valid), 32'd0);
      check("misalign", 32'(misalign_err), 32'(exp_mis));
   endtask

   initial begin
      rst_n      = 1'b0;
      stall      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      last_instr = '0;
      clear_redirects();

      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_pc", pc_out, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_mis", 32'(misalign_err), 32'd0);
      rst_n = 1'b1;

      // Zero-wait sequential fetches: one instruction per two cycles.
      fetch(0, 32'h0);   exec_step(32'h4, 1'b0);
      fetch(0, 32'h4);   exec_step(32'h8, 1'b0);
      fetch(0, 32'h8);   exec_step(32'hC, 1'b0);
      fetch(0, 32'hC);   exec_step(32'h10, 1'b0);

      // Three-cycle ack delay, then a jump to 0x100.
      fetch(3, 32'h10);
      jump = 1'b1; jump_index_sh = 28'h000_0100;
      exec_step(32'h100, 1'b0);

      // Backward branch: 0x104 + 0xFFFF_FFF0 = 0xF4.
      fetch(0, 32'h100);
      check("pc_plus4", pc_plus4, 32'h104);
      branch_taken = 1'b1; branch_offset_sh = 32'hFFFF_FFF0;
      exec_step(32'hF4, 1'b0);

      // Jump outranks a taken branch.
      fetch(0, 32'hF4);
      branch_taken = 1'b1; branch_offset_sh = 32'h0000_0040;
      jump = 1'b1; jump_index_sh = 28'h000_0200;
      exec_step(32'h200, 1'b0);

      // Misaligned jr (outranking j) lands on the exception vector with a pulse.
      fetch(0, 32'h200);
      jump_reg = 1'b1; jr_target = 32'h0000_2002;
      jump = 1'b1; jump_index_sh = 28'h000_0300;
      exec_step(32'h180, 1'b1);

      fetch(0, 32'h180);
      jump_reg = 1'b1; jr_target = 32'h0000_0400;
      exec_step(32'h400, 1'b0);

      // Exception outranks jr.
      fetch(0, 32'h400);
      exc = 1'b1; jump_reg = 1'b1; jr_target = 32'h0000_0800;
      exec_step(32'h180, 1'b0);

      // Stall for four EXEC cycles with branch_taken toggling.
      fetch(0, 32'h180);
      branch_offset_sh = 32'h0000_0040;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         branch_taken = (i % 2) == 0;
         @(negedge clk);
         check("stall_pc", pc_out, 32'h180);
         check("stall_instr", instr, last_instr);
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_req", 32'(imem_req), 32'd0);
      end
      branch_taken = 1'b0;
      exec_step(32'h184, 1'b0);

      fetch(0, 32'h184);
      branch_taken = 1'b1; branch_offset_sh = 32'h0000_0040;
      exec_step(32'h1C8, 1'b0);

      // Address wrap at the top of memory.
      fetch(0, 32'h1C8);
      jump_reg = 1'b1; jr_target = 32'hFFFF_FFFC;
      exec_step(32'hFFFF_FFFC, 1'b0);
      fetch(0, 32'hFFFF_FFFC);
      check("wrap_plus4", pc_plus4, 32'h0);
      exec_step(32'h0, 1'b0);

      // Reset in the middle of a fetch, with an ack pending.
      fetch(0, 32'h0);
      jump = 1'b1; jump_index_sh = 28'h000_0300;
      exec_step(32'h300, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      rst_n      = 1'b0;
      #1;
      check("arst_req", 32'(imem_req), 32'd0);
      check("arst_pc", pc_out, 32'h0);
      @(negedge clk);
      check("arst_valid", 32'(instr_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req", 32'(imem_req), 32'd1);
      check("post_rst_valid", 32'(instr_valid), 32'd0);
      check("post_rst_instr", instr, 32'h0);
      imem_ack = 1'b0;
      fetch(0, 32'h0);
      exec_step(32'h4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
